// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizing for the SDRAM arbiter.
package sdram_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 3;
  localparam int unsigned DEF_ADDR_W  = 23;
  localparam int unsigned DEF_DATA_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_READ = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester-side and SDRAM-side bus of the arbiter; master is the arbiter's view.
interface sdram_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W
);

  logic [NUM_REQ-1:0]             req_read;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_writedata;
  logic [DATA_W-1:0]              req_readdata;
  logic [NUM_REQ-1:0]             req_finished;

  logic [ADDR_W-1:0]              sdram_addr;
  logic [DATA_W-1:0]              sdram_writedata;
  logic                           sdram_read;
  logic                           sdram_write;
  logic                           sdram_waitrequest;
  logic [DATA_W-1:0]              sdram_readdata;
  logic                           sdram_readdatavalid;

  logic                           busy;
  logic [$clog2(NUM_REQ)-1:0]     grant_id;

  modport master (
    input  req_read, req_write, req_addr, req_writedata,
    input  sdram_waitrequest, sdram_readdata, sdram_readdatavalid,
    output req_readdata, req_finished,
    output sdram_addr, sdram_writedata, sdram_read, sdram_write,
    output busy, grant_id
  );

  modport slave (
    output req_read, req_write, req_addr, req_writedata,
    output sdram_waitrequest, sdram_readdata, sdram_readdatavalid,
    input  req_readdata, req_finished,
    input  sdram_addr, sdram_writedata, sdram_read, sdram_write,
    input  busy, grant_id
  );

endinterface

// File: rtl/sdram_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping to 0.
module rr_picker #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] index
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  int unsigned cand;

  // Scan offsets 1..NUM_REQ so last_grant itself is considered last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(last_grant) + i) % NUM_REQ;
      if (!valid && req[ID_W'(cand)]) begin
        valid = 1'b1;
        index = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter giving several requesters single-command access to one SDRAM port.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input  logic            i_clk,
  input  logic            i_rst,
  sdram_arbiter_if.master bus
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [NUM_REQ-1:0] fin_q, fin_d;
  logic               busy_q, busy_d;

  logic               pick_valid;
  logic [ID_W-1:0]    pick_idx;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (bus.req_read | bus.req_write),
    .last_grant (last_q),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    fin_d   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_ISSUE;
          grant_d = pick_idx;
          addr_d  = bus.req_addr[pick_idx];
          wdata_d = bus.req_writedata[pick_idx];
          // Write has priority when a requester raises both.
          wr_d    = bus.req_write[pick_idx];
          rd_d    = ~bus.req_write[pick_idx];
        end
      end
      ST_ISSUE: begin
        if (!bus.sdram_waitrequest) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (wr_q) begin
            state_d = ST_DONE;
            fin_d   = NUM_REQ'(1) << grant_q;
          end else if (bus.sdram_readdatavalid) begin
            state_d = ST_DONE;
            rdata_d = bus.sdram_readdata;
            fin_d   = NUM_REQ'(1) << grant_q;
          end else begin
            state_d = ST_WAIT_READ;
          end
        end
      end
      ST_WAIT_READ: begin
        if (bus.sdram_readdatavalid) begin
          state_d = ST_DONE;
          rdata_d = bus.sdram_readdata;
          fin_d   = NUM_REQ'(1) << grant_q;
        end
      end
      ST_DONE: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      fin_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.sdram_addr      = addr_q;
  assign bus.sdram_writedata = wdata_q;
  assign bus.sdram_read      = rd_q;
  assign bus.sdram_write     = wr_q;
  assign bus.req_readdata    = rdata_q;
  assign bus.req_finished    = fin_q;
  assign bus.busy            = busy_q;
  assign bus.grant_id        = grant_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter with hand-computed expectations.
module tb_sdram_arbiter;

  logic i_clk;
  logic i_rst;

  int n_checks;
  int n_fail;

  sdram_arbiter_if #(.NUM_REQ(3), .ADDR_W(23), .DATA_W(32)) bus ();

  sdram_arbiter #(.NUM_REQ(3), .ADDR_W(23), .DATA_W(32)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; sample and drive 1ns after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_read  = '0;
    bus.req_write = '0;
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    tick();
    tick();
    i_rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    i_rst    = 1'b0;
    clear_reqs();
    bus.req_addr            = '0;
    bus.req_writedata       = '0;
    bus.sdram_waitrequest   = 1'b0;
    bus.sdram_readdata      = '0;
    bus.sdram_readdatavalid = 1'b0;

    // Reset state
    tick();
    tick();
    check_eq("rst_busy",     64'(bus.busy), 64'd0);
    check_eq("rst_grant",    64'(bus.grant_id), 64'd0);
    check_eq("rst_rd",       64'(bus.sdram_read), 64'd0);
    check_eq("rst_wr",       64'(bus.sdram_write), 64'd0);
    check_eq("rst_addr",     64'(bus.sdram_addr), 64'd0);
    check_eq("rst_wdata",    64'(bus.sdram_writedata), 64'd0);
    check_eq("rst_rdata",    64'(bus.req_readdata), 64'd0);
    check_eq("rst_fin",      64'(bus.req_finished), 64'd0);
    i_rst = 1'b1;

    // Single write from requester 0, accepted immediately
    bus.req_write[0]     = 1'b1;
    bus.req_addr[0]      = 23'h000010;
    bus.req_writedata[0] = 32'hDEADBEEF;
    tick();
    check_eq("w0_strobe",    64'(bus.sdram_write), 64'd1);
    check_eq("w0_rd",        64'(bus.sdram_read), 64'd0);
    check_eq("w0_addr",      64'(bus.sdram_addr), 64'h10);
    check_eq("w0_data",      64'(bus.sdram_writedata), 64'hDEADBEEF);
    check_eq("w0_grant",     64'(bus.grant_id), 64'd0);
    check_eq("w0_busy",      64'(bus.busy), 64'd1);
    check_eq("w0_fin_early", 64'(bus.req_finished), 64'd0);
    tick();
    check_eq("w0_fin",       64'(bus.req_finished), 64'b001);
    check_eq("w0_strobe_dn", 64'(bus.sdram_write), 64'd0);
    clear_reqs();
    tick();
    check_eq("w0_fin_once",  64'(bus.req_finished), 64'd0);
    check_eq("w0_idle",      64'(bus.busy), 64'd0);

    // Read from requester 1 with 3 wait cycles and delayed data
    bus.req_read[1]       = 1'b1;
    bus.req_addr[1]       = 23'h7FFFFF;
    bus.sdram_waitrequest = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("r1_hold%0d", k), 64'(bus.sdram_read), 64'd1);
      tick();
    end
    check_eq("r1_hold3",     64'(bus.sdram_read), 64'd1);
    check_eq("r1_addr",      64'(bus.sdram_addr), 64'h7FFFFF);
    check_eq("r1_grant",     64'(bus.grant_id), 64'd1);
    bus.sdram_waitrequest = 1'b0;
    tick();
    check_eq("r1_strobe_dn", 64'(bus.sdram_read), 64'd0);
    check_eq("r1_busy",      64'(bus.busy), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("r1_wait%0d", k), 64'(bus.req_finished), 64'd0);
      tick();
    end
    bus.sdram_readdatavalid = 1'b1;
    bus.sdram_readdata      = 32'h12345678;
    tick();
    bus.sdram_readdatavalid = 1'b0;
    check_eq("r1_fin",       64'(bus.req_finished), 64'b010);
    check_eq("r1_rdata",     64'(bus.req_readdata), 64'h12345678);
    clear_reqs();
    tick();
    check_eq("r1_fin_once",  64'(bus.req_finished), 64'd0);

    // Three requesters writing continuously: fair rotation from reset
    do_reset();
    for (int r = 0; r < 3; r++) begin
      bus.req_addr[r]      = 23'(32'h100 + 32'(r));
      bus.req_writedata[r] = 32'hA0 + 32'(r);
    end
    bus.req_write = 3'b111;
    for (int t = 0; t < 6; t++) begin
      tick();
      check_eq($sformatf("rr%0d_grant", t), 64'(bus.grant_id), 64'(t % 3));
      check_eq($sformatf("rr%0d_addr", t),  64'(bus.sdram_addr), 64'(32'h100 + 32'(t % 3)));
      tick();
      check_eq($sformatf("rr%0d_fin", t),   64'(bus.req_finished), 64'(3'b001 << (t % 3)));
      tick();
    end
    clear_reqs();
    tick();

    // Requester 2 with read and write both high: write wins
    bus.req_read[2]      = 1'b1;
    bus.req_write[2]     = 1'b1;
    bus.req_addr[2]      = 23'h000222;
    bus.req_writedata[2] = 32'hCAFEF00D;
    tick();
    check_eq("rw2_wr",       64'(bus.sdram_write), 64'd1);
    check_eq("rw2_rd",       64'(bus.sdram_read), 64'd0);
    check_eq("rw2_grant",    64'(bus.grant_id), 64'd2);
    tick();
    check_eq("rw2_fin",      64'(bus.req_finished), 64'b100);
    clear_reqs();
    tick();
    check_eq("rw2_fin_once", 64'(bus.req_finished), 64'd0);
    check_eq("rw2_rd_never", 64'(bus.sdram_read), 64'd0);

    // Spurious readdatavalid while idle
    bus.sdram_readdatavalid = 1'b1;
    bus.sdram_readdata      = 32'hAAAA5555;
    tick();
    bus.sdram_readdatavalid = 1'b0;
    check_eq("spur_rdata",   64'(bus.req_readdata), 64'd0);
    check_eq("spur_fin",     64'(bus.req_finished), 64'd0);
    check_eq("spur_busy",    64'(bus.busy), 64'd0);

    // Reset during WAIT_READ, then a late readdatavalid
    bus.req_read[0] = 1'b1;
    bus.req_addr[0] = 23'h000ABC;
    tick();
    check_eq("ab_rd",        64'(bus.sdram_read), 64'd1);
    tick();
    check_eq("ab_waiting",   64'(bus.busy), 64'd1);
    i_rst = 1'b0;
    #1;
    check_eq("ab_busy_rst",  64'(bus.busy), 64'd0);
    check_eq("ab_rd_rst",    64'(bus.sdram_read), 64'd0);
    clear_reqs();
    tick();
    i_rst = 1'b1;
    tick();
    bus.sdram_readdatavalid = 1'b1;
    bus.sdram_readdata      = 32'h55AA55AA;
    tick();
    bus.sdram_readdatavalid = 1'b0;
    check_eq("ab_fin",       64'(bus.req_finished), 64'd0);
    check_eq("ab_rdata",     64'(bus.req_readdata), 64'd0);
    check_eq("ab_idle",      64'(bus.busy), 64'd0);
    tick();
    check_eq("ab_fin2",      64'(bus.req_finished), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
